// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the parametrised vending-machine controller.
//   COIN_*        coin-acceptor event encodings
//   vend_state_e  credit FSM state encoding (2'b11 is illegal and recovers to IDLE)
//   coin_value()  decodes a coin event into base units (0 for none/invalid)
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCUM  = 2'b01,
        ST_REFUND = 2'b10
    } vend_state_e;

    function automatic logic [1:0] coin_value(input logic [1:0] coin);
        logic [1:0] v;
        v = 2'd0;
        case (coin)
            COIN_ONE: v = 2'd1;
            COIN_TWO: v = 2'd2;
            default:  v = 2'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_change_ctr.sv
// vend_change_ctr: surplus-change counter feeding the change hopper.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        force the counter to zero (illegal-state recovery)
//   load         load load_val (takes priority over a decrement)
//   load_val     number of change units to return
//   req          registered change request currently presented to the hopper
//   hop_ready    hopper accepts one unit this cycle
//   done         combinational: the final unit transfers at the coming edge
module vend_change_ctr #(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                req,
    input  logic                hop_ready,
    output logic                done
);

    logic [CREDIT_W-1:0] cnt;
    logic                xfer;

    // One unit leaves per cycle in which the request meets a ready hopper.
    assign xfer = req & hop_ready;

    // Treating a zero count as "last" lets a corrupted count still exit REFUND.
    assign done = xfer & (cnt <= CREDIT_W'(1));

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (xfer && cnt != '0) begin
            cnt <= cnt - CREDIT_W'(1);
        end
    end

endmodule

// File: rtl/vend_fsm_param.sv
// vend_fsm_param: parametrised vending-machine credit controller.
// Accumulates coin credit against PRICE, pulses sell, then returns surplus
// one unit per hopper handshake. Coins arriving while busy are rejected.
// Build option: define VEND_CANCEL_EN to honour the cancel input (refund of
// accumulated credit from ACCUM); otherwise cancel is ignored.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   coin         coin event: 00 none, 01 one unit, 10 two units, 11 invalid
//   cancel       refund request level (ACCUM only, VEND_CANCEL_EN builds)
//   hop_ready    hopper accepts one change unit this cycle
//   sell         one-cycle dispense pulse
//   change_req   hopper request, high throughout REFUND
//   coin_rej     one-cycle pulse: the sampled coin was not credited
//   busy         high while returning change
//   credit       current accumulated credit
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                hop_ready,
    output logic                sell,
    output logic                change_req,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

    vend_state_e         state, next_state;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                sell_q, sell_d;
    logic                rej_q, rej_d;
    logic                req_q;
    logic                ctr_clear, ctr_load, ctr_done;
    logic [CREDIT_W-1:0] ctr_load_val;
    logic [CREDIT_W-1:0] sum;
    logic [1:0]          coin_v;
    logic                coin_any;
    logic                cancel_act;

`ifdef VEND_CANCEL_EN
    assign cancel_act = cancel & (state == ST_ACCUM);
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_act    = 1'b0;
`endif

    assign coin_v   = coin_value(coin);
    assign coin_any = (coin != COIN_NONE);
    assign sum      = credit_q + CREDIT_W'(coin_v);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        credit_d     = credit_q;
        sell_d       = 1'b0;
        rej_d        = 1'b0;
        ctr_clear    = 1'b0;
        ctr_load     = 1'b0;
        ctr_load_val = '0;

        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (cancel_act) begin
                    // Cancel wins over a same-edge coin, which goes back.
                    ctr_load     = 1'b1;
                    ctr_load_val = credit_q;
                    credit_d     = '0;
                    rej_d        = coin_any;
                    next_state   = ST_REFUND;
                end else if (coin == COIN_BAD) begin
                    rej_d = 1'b1;
                end else if (coin_v != 2'd0) begin
                    if (sum < PRICE_W) begin
                        credit_d   = sum;
                        next_state = ST_ACCUM;
                    end else begin
                        sell_d       = 1'b1;
                        credit_d     = '0;
                        ctr_load     = 1'b1;
                        ctr_load_val = sum - PRICE_W;
                        next_state   = (sum != PRICE_W) ? ST_REFUND : ST_IDLE;
                    end
                end
            end
            ST_REFUND: begin
                // Includes the edge of the last transfer: that coin is returned.
                rej_d = coin_any;
                if (ctr_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                credit_d   = '0;
                ctr_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            credit_q <= '0;
            sell_q   <= 1'b0;
            rej_q    <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state    <= next_state;
            credit_q <= credit_d;
            sell_q   <= sell_d;
            rej_q    <= rej_d;
            // Mirrors (state == REFUND) from its own flop so the hopper sees a
            // clean registered request.
            req_q    <= (next_state == ST_REFUND);
        end
    end

    vend_change_ctr #(
        .CREDIT_W (CREDIT_W)
    ) u_change_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ctr_clear),
        .load      (ctr_load),
        .load_val  (ctr_load_val),
        .req       (req_q),
        .hop_ready (hop_ready),
        .done      (ctr_done)
    );

    assign sell       = sell_q;
    assign coin_rej   = rej_q;
    assign change_req = req_q;
    assign busy       = req_q;
    assign credit     = credit_q;

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending-machine controller, successor to the fixed-price 2-bit coin FSM. Accumulates credit from coin events against a configurable price, pulses `sell`, then returns any surplus one unit per handshake to a change hopper. Supports cancel/refund and rejects coins while busy. Sits between the coin-acceptor front end and the dispense/hopper drivers.

## Interface
- `PRICE`, 3: item price in base units (1 unit = 0.5 currency); legal range 1..2^CREDIT_W-3
- `CREDIT_W`, 4: width of credit and change counters; must hold PRICE+1
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `coin`  in  2  coin event, sampled each edge: 00 none, 01 one unit, 10 two units, 11 invalid
- `cancel`  in  1  level, sampled each edge; refund accumulated credit
- `hop_ready`  in  1  hopper accepts one change unit this cycle
- `sell`  out  1  one-cycle dispense pulse
- `change_req`  out  1  hopper request; one unit transferred per cycle with `change_req & hop_ready`
- `coin_rej`  out  1  one-cycle pulse: sampled coin was not credited (return it)
- `busy`  out  1  high while returning change
- `credit`  out  CREDIT_W  current accumulated credit

## Operation
- States: IDLE (credit 0), ACCUM (0 < credit < PRICE), REFUND (change_cnt > 0). Illegal state encodings → IDLE, counters cleared.
- Reset (async, immediate): state IDLE; credit, change_cnt, sell, change_req, coin_rej, busy all 0. Reset mid-REFUND discards remaining change.
- IDLE/ACCUM, valid coin value v: sum = credit + v.
  - sum < PRICE: credit ← sum, state ACCUM.
  - sum ≥ PRICE: sell ← 1, credit ← 0, change_cnt ← sum − PRICE; state REFUND if change_cnt ≠ 0, else IDLE.
- coin = 11 in any state: coin_rej pulse, credit unchanged.
- REFUND: any nonzero coin → coin_rej pulse, not credited. Each cycle with change_req & hop_ready: change_cnt −1; when it reaches 0, state IDLE and change_req drops at the same edge. hop_ready low: hold, no timeout.
- Cancel (ACCUM only): change_cnt ← credit, credit ← 0, state REFUND, no sell. Cancel in IDLE or REFUND: no effect. Cancel with simultaneous coin in ACCUM: cancel wins, coin rejected (coin_rej).
- change_req = busy = (state == REFUND), registered.
- Arithmetic unsigned, CREDIT_W bits; no overflow by parameter constraint.

## Timing
- All outputs registered; no combinational input→output path.
- Coin sampled at edge N → credit / sell / coin_rej / change_req valid after edge N (one-cycle latency).
- sell and coin_rej are exactly one cycle wide per event; back-to-back coins yield back-to-back updates, no dead cycle.
- First change unit may transfer in the cycle after sell; N units need ≥ N cycles.
- New coins accepted at the edge where the last change unit transfers only from the following cycle (that edge's coin is rejected).

## Configuration
- `VEND_CANCEL_EN` defined: cancel behaves as above.
- Not defined: `cancel` port present but ignored; credit held until price reached; coin never rejected for cancel conflict.

## Structure
- Package `vend_pkg`: coin encodings (COIN_NONE/ONE/TWO/BAD), state enum, coin-value decode function.
- Sub-module `vend_change_ctr`: change_cnt load/decrement with hop_ready handshake, outputs done flag; top holds the credit FSM.

## Test plan
- PRICE=3: coins 01,01,01 → credit 1,2; sell pulse after third; change_req never asserts.
- PRICE=3: coins 10,10 → sell after second, change_req high, hop_ready held 1 → one transfer, back to IDLE next cycle.
- PRICE=3, credit 2, hop_ready low 5 cycles then high, coin 10 during REFUND → coin_rej pulse, change held until hop_ready, one unit returned.
- `VEND_CANCEL_EN`, credit 2, cancel with coin 01 same edge → coin_rej, no sell, two units returned; without macro → credit 3, sell.
- coin 11 in IDLE → coin_rej, credit 0; rst_n low mid-REFUND → all outputs 0 immediately, IDLE.
- PRICE=5, CREDIT_W=4: credit 4 + coin 10 → sell, change 1.
